// File: rtl/tx_packet_arbiter.sv
// tx_packet_arbiter: round-robin sharing of one packet transmitter among NUM_REQ requesters with end-of-packet byte counting and a stall watchdog
module tx_packet_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUMBER  = 256,
  parameter int TIMEOUT = 100000,
  parameter int LEN_W   = $clog2(NUMBER)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       req_cmd,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  input  logic [NUM_REQ*8-1:0]       req_rd_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         err,
  output logic [NUM_REQ-1:0]         req_rd_clock,
  output logic                       start_pckt,
  output logic [7:0]                 cmd_tx,
  output logic [LEN_W-1:0]           len_tx,
  input  logic [LEN_W-1:0]           rd_addr_in,
  input  logic                       rd_clock_in,
  output logic [7:0]                 rd_data,
  input  logic                       tx_done,
  output logic                       busy
);
  localparam int CNT_W = LEN_W + 2;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int PTR_W = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, START, SEND, FINISH} state_t;
  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant, r_done, r_err;
  logic               r_start;
  logic [7:0]         r_cmd;
  logic [LEN_W-1:0]   r_len;
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [WD_W-1:0]    r_wd;
  logic [PTR_W-1:0]   w_win, w_k;
  logic               w_any;
  logic [CNT_W-1:0]   w_n;
  logic [7:0]         w_rd_data;
  logic               w_unused_addr;
  always_comb begin
    w_win = r_ptr;
    w_any = 1'b0;
    w_k   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_k = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
      if (req[w_k]) begin
        w_win = w_k;
        w_any = 1'b1;
      end
    end
  end
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_rd_data = w_rd_data | (req_rd_data[8*i +: 8] & {8{r_grant[i]}});
  end
  assign w_n           = ((r_len == '0) ? CNT_W'(NUMBER) : CNT_W'(r_len)) + CNT_W'(3);
  assign w_unused_addr = ^rd_addr_in;
  assign rd_data       = w_rd_data;
  assign req_rd_clock  = r_grant & {NUM_REQ{rd_clock_in}};
  assign grant         = r_grant;
  assign done          = r_done;
  assign err           = r_err;
  assign start_pckt    = r_start;
  assign cmd_tx        = r_cmd;
  assign len_tx        = r_len;
  assign busy          = r_state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_start <= 1'b0;
      r_cmd   <= '0;
      r_len   <= '0;
      r_ptr   <= PTR_W'(NUM_REQ - 1);
      r_cnt   <= '0;
      r_wd    <= '0;
    end else begin
      r_done  <= '0;
      r_err   <= '0;
      r_start <= 1'b0;
      case (r_state)
        IDLE: if (w_any) begin
          r_grant <= NUM_REQ'(1) << w_win;
          r_cmd   <= req_cmd[8*w_win +: 8];
          r_len   <= req_len[LEN_W*w_win +: LEN_W];
          r_ptr   <= w_win;
          r_start <= 1'b1;
          r_cnt   <= '0;
          r_wd    <= '0;
          r_state <= START;
        end
        START: begin
          r_cnt   <= '0;
          r_wd    <= '0;
          r_state <= SEND;
        end
        SEND: if (tx_done) begin
          r_wd  <= '0;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt + 1'b1 == w_n) begin
            r_state <= FINISH;
            r_grant <= '0;
            r_done  <= r_grant;
          end
        end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
          r_state <= FINISH;
          r_grant <= '0;
          r_err   <= r_grant;
        end else begin
          r_wd <= r_wd + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_packet_arbiter.sv
// tb_tx_packet_arbiter: randomized packets checked against a transaction-level round-robin / byte-count / watchdog model
module tb_tx_packet_arbiter;
  localparam int NR = 4;
  localparam int NUMBER = 256;
  localparam int LW = 8;
  localparam int TO = 50;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*8-1:0] req_cmd = '0;
  logic [NR*LW-1:0] req_len = '0;
  logic [NR*8-1:0] req_rd_data = '0;
  logic [NR-1:0] grant, done, err, req_rd_clock;
  logic start_pckt, busy;
  logic [7:0] cmd_tx, rd_data;
  logic [LW-1:0] len_tx;
  logic [LW-1:0] rd_addr_in = '0;
  logic rd_clock_in = 1'b0;
  logic tx_done = 1'b0;
  int n_err = 0;
  int n_chk = 0;
  int m_ptr = NR - 1;

  tx_packet_arbiter #(.NUM_REQ(NR), .NUMBER(NUMBER), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_cmd(req_cmd), .req_len(req_len),
    .req_rd_data(req_rd_data), .grant(grant), .done(done), .err(err),
    .req_rd_clock(req_rd_clock), .start_pckt(start_pckt), .cmd_tx(cmd_tx),
    .len_tx(len_tx), .rd_addr_in(rd_addr_in), .rd_clock_in(rd_clock_in),
    .rd_data(rd_data), .tx_done(tx_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] r);
    for (int i = 1; i <= NR; i++)
      if (r[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
    return -1;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_doneerr"}, 32'({done, err}), 0);
    chk({tag, "_start"}, 32'(start_pckt), 0);
  endtask

  task automatic pkt(input logic [NR-1:0] r, input int fcmd, input int flen, input int stall_at, input int rst_at);
    int w, n, sent, idle;
    logic [7:0] c;
    logic [LW-1:0] l;
    bit prev, fin;
    req = r;
    for (int i = 0; i < NR; i++) begin
      req_cmd[8*i +: 8] = (fcmd < 0) ? 8'($urandom) : 8'(fcmd);
      req_len[LW*i +: LW] = (flen >= 0) ? LW'(flen) :
                            ($urandom_range(0, 7) == 0) ? '0 : LW'($urandom_range(1, 12));
    end
    tx_done = 1'($urandom);
    w = pick(r);
    c = req_cmd[8*w +: 8];
    l = req_len[LW*w +: LW];
    n = ((l == 0) ? NUMBER : int'(l)) + 3;
    @(negedge clk);
    chk("grant", 32'(grant), 32'(1 << w));
    chk("start", 32'(start_pckt), 1);
    chk("cmd", 32'(cmd_tx), 32'(c));
    chk("len", 32'(len_tx), 32'(l));
    chk("busy", 32'(busy), 1);
    m_ptr = w;
    req_cmd = {NR{8'($urandom)}};
    req[w] = 1'($urandom);
    tx_done = 1'b1;
    prev = 1'b0;
    sent = 0;
    idle = 0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      if (prev) begin
        sent++;
        idle = 0;
      end else if (cyc > 0) idle++;
      if (rst_at >= 0 && sent == rst_at) begin
        reset = 1'b1;
        tx_done = 1'b0;
        req = '0;
        @(negedge clk);
        reset = 1'b0;
        chk_idle("rst");
        chk("rst_cmd", 32'(cmd_tx), 0);
        chk("rst_len", 32'(len_tx), 0);
        m_ptr = NR - 1;
        tx_done = 1'b1;
        @(negedge clk);
        chk_idle("rst_after");
        tx_done = 1'b0;
        return;
      end
      if (sent == n || idle == TO) begin
        chk("done", 32'(done), (sent == n) ? 32'(1 << w) : 0);
        chk("err", 32'(err), (idle == TO) ? 32'(1 << w) : 0);
        chk("grant_off", 32'(grant), 0);
        fin = 1'b1;
      end else begin
        chk("no_end", 32'({done, err}), 0);
        chk("grant_hold", 32'(grant), 32'(1 << w));
        chk("start_once", 32'(start_pckt), 0);
        chk("cmd_hold", 32'({cmd_tx, len_tx}), 32'({c, l}));
      end
      prev = (stall_at >= 0 && sent >= stall_at) ? 1'b0 : ($urandom_range(0, 2) != 0);
      tx_done = fin ? 1'b0 : prev;
      if (fin) req = '0;
      rd_clock_in = 1'($urandom);
      rd_addr_in = LW'($urandom);
      req_rd_data = {$urandom, $urandom};
      #1;
      chk("rd_data", 32'(rd_data), fin ? 0 : 32'(req_rd_data[8*w +: 8]));
      chk("rd_clock", 32'(req_rd_clock), (fin || !rd_clock_in) ? 0 : 32'(1 << w));
    end
    chk("pkt_end", 32'(fin), 1);
    @(negedge clk);
    chk_idle("gap");
    tx_done = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_cmd", 32'(cmd_tx), 0);
    chk("reset_len", 32'(len_tx), 0);
    chk("reset_rd", 32'(rd_data), 0);
    reset = 1'b0;
    @(negedge clk);
    pkt(4'b0001, 8'hA5, 3, -1, -1);
    for (int i = 0; i < 5; i++) pkt(4'b1111, -1, 1, -1, -1);
    pkt(4'b0100, -1, 0, -1, -1);
    pkt(4'b1000, -1, 5, 2, -1);
    pkt(4'b0010, -1, 5, -1, 3);
    pkt(4'b1111, -1, 2, -1, -1);
    pkt(4'b0010, -1, 4, -1, -1);
    for (int i = 0; i < 30; i++)
      pkt(4'($urandom_range(1, 15)), -1, -1, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1, -1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/tx_packet_arbiter.md
Name: tx_packet_arbiter

Overview:
- Shares one UART packet transmitter (packet sequencer plus byte transmitter) among NUM_REQ requesters using round-robin arbitration.
- Latches the winner's command and length, issues the packet start strobe, and routes the transmitter's payload-buffer read port to the winner's buffer.
- Counts byte-completion pulses to detect end of packet, then releases the grant and signals done.
- Includes a watchdog that aborts a stalled packet.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUMBER, 256, maximum payload bytes; LEN_W = clogb2(NUMBER).
- TIMEOUT, 100000, max clk cycles between consecutive tx_done pulses before abort.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester packet request, level, held until done/err
- req_cmd  in  NUM_REQ*8  command bytes, requester i at [8i+7:8i]
- req_len  in  NUM_REQ*LEN_W  payload lengths; 0 means NUMBER
- req_rd_data  in  NUM_REQ*8  payload buffer read data per requester
- grant  out  NUM_REQ  one-hot grant, 0 when idle
- done  out  NUM_REQ  one-cycle pulse to granted requester on successful completion
- err  out  NUM_REQ  one-cycle pulse to granted requester on watchdog abort
- req_rd_clock  out  NUM_REQ  rd_clock routed to granted requester only
- start_pckt  out  1  packet start strobe to sequencer
- cmd_tx  out  8  latched command of winner
- len_tx  out  LEN_W  latched length of winner
- rd_addr_in  in  LEN_W  sequencer buffer address, broadcast (requesters use it when granted)
- rd_clock_in  in  1  sequencer buffer read strobe
- rd_data  out  8  muxed req_rd_data of granted requester, combinational
- tx_done  in  1  one-cycle pulse from byte transmitter at end of each byte frame
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE; grant, done, err, req_rd_clock, start_pckt = 0; cmd_tx, len_tx = 0; rr pointer = NUM_REQ-1, so requester 0 has first priority; byte counter and watchdog = 0.
- FSM states: IDLE, START, SEND, FINISH.
- IDLE: if any req bit is high, pick the first set bit scanning from pointer+1 with wrap. Register grant (one-hot), latch cmd_tx/len_tx from that slice, set pointer to the winner, go to START. Grant is visible one cycle after req is sampled.
- START: start_pckt = 1 for exactly one cycle; clear byte counter and watchdog; go to SEND.
- SEND: expected byte count N = (len_tx==0 ? NUMBER : len_tx) + 3 (cmd, len, payload, checksum).
  - Counter width LEN_W+2, no wrap possible.
  - Each tx_done increments the counter and clears the watchdog; otherwise the watchdog increments.
  - When the counter reaches N on a tx_done, go to FINISH with done-type = ok.
  - If the watchdog reaches TIMEOUT-1 without tx_done, go to FINISH with done-type = abort.
- FINISH: pulse done[winner] or err[winner] for one cycle; clear grant in the same cycle; go to IDLE.
  - A requester still holding req is eligible again only after the other requesters' turns.
- cmd_tx and len_tx stay stable from START through FINISH; req and req_cmd changes during a packet are ignored.
- rd_data = req_rd_data slice selected by grant; 0 when grant == 0. req_rd_clock = grant & {NUM_REQ{rd_clock_in}}.
- tx_done while in IDLE or START is ignored; it is not counted.
- A req drop mid-packet is ignored; the packet completes or times out.
- Simultaneous requests are resolved strictly by the round-robin pointer; there is no fixed priority after the first grant.
- Reset mid-packet: immediate return to IDLE with all outputs at reset values and no done/err pulse. The sequencer must share the same reset.
- Back-to-back: minimum gap of 2 cycles (FINISH, IDLE) between the last tx_done of one packet and the next grant.

Test Plan:
- Single request: req=0001, len=3, cmd=0xA5 -> grant=0001 one cycle later; one start_pckt pulse with cmd_tx=0xA5, len_tx=3; done[0] pulse on the 6th tx_done; grant=0.
- Round-robin: req=1111 held, each packet len=1 -> grant order 0,1,2,3,0; each packet gets exactly 4 tx_done pulses before done.
- len=0 with NUMBER=256 -> done only after 259 tx_done pulses; rd_addr_in 0..255 routed to the granted requester; other requesters see req_rd_clock=0.
- Watchdog with TIMEOUT=50: stop tx_done after 2 bytes -> err[i] pulse exactly 50 cycles after the last tx_done; no done pulse; IDLE next cycle.
- Reset asserted mid-SEND after 3 bytes -> next cycle grant=0, busy=0, no done/err; a new req afterwards is served from requester 0 priority.
- Mid-packet req drop and req_cmd change on requester 1 -> cmd_tx unchanged; packet still completes with done[1].
